// File: rtl/ppu_video_pkg.sv
// Shared definitions for the PPU scan-out path.
//   - Raster timing defaults (320x200 visible, 400x262 total).
//   - pixel_t: packed RGB888 pixel {r, g, b}.
//   - expand5 / rgb555_to_888: RGB555 to RGB888 channel expansion.
package ppu_video_pkg;

  localparam int unsigned H_ACTIVE = 320;
  localparam int unsigned H_FRONT  = 8;
  localparam int unsigned H_SYNC   = 32;
  localparam int unsigned H_BACK   = 40;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  localparam int unsigned V_ACTIVE = 200;
  localparam int unsigned V_FRONT  = 3;
  localparam int unsigned V_SYNC   = 4;
  localparam int unsigned V_BACK   = 55;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Raster counter width; covers both H_TOTAL and V_TOTAL.
  localparam int unsigned CNT_W = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Replicate the top bits into the low bits so 5'h1F maps to 8'hFF.
  function automatic logic [7:0] expand5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  function automatic pixel_t rgb555_to_888(input logic [14:0] c);
    pixel_t p;
    p.r = expand5(c[14:10]);
    p.g = expand5(c[9:5]);
    p.b = expand5(c[4:0]);
    return p;
  endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// 256x15 simple dual-port palette RAM, synchronous read, read-first.
// Ports:
//   clk_in, reset_n : clock / async active-low reset (read register only)
//   we_i, waddr_i, wdata_i : write port
//   re_i, raddr_i   : read port; data appears on rdata_o one cycle after re_i
//   rdata_o         : RGB555 read data
// Memory contents are deliberately not reset.
module ppu_palette_ram (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [14:0] wdata_i,
  input  logic        re_i,
  input  logic [7:0]  raddr_i,
  output logic [14:0] rdata_o
);

  logic [14:0] mem_q [256];
  logic [14:0] rdata_q;

  always_ff @(posedge clk_in) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // The read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ppu_scanout.sv
// PPU scan-out: raster timing, index fetch, palette lookup, RGB888 output.
// Optional feature macro: PPU_FADE_EN (master brightness scaling in stage 3).
// Ports:
//   clk_in, reset_n        : clock / async active-low reset
//   pix_ce                 : pixel clock enable; all raster/pipeline state moves only when high
//   idx_data, idx_valid    : palette index stream from the compositor
//   idx_ready              : index consumed this cycle (combinational)
//   pal_we/pal_addr/pal_wdata : palette write port (RGB555)
//   brightness             : master brightness, used only with PPU_FADE_EN
//   pixel_r/g/b, hsync, vsync, de : video out, 3 enables after the counter position
//   frame_start            : pulse at raster (0,0) on pix_ce
//   line_num               : current raster line (counter stage)
//   underflow, underflow_clr : sticky missing-index flag and its clear
module ppu_scanout
  import ppu_video_pkg::*;
#(
  parameter int unsigned HActive = H_ACTIVE,
  parameter int unsigned HFront  = H_FRONT,
  parameter int unsigned HSync   = H_SYNC,
  parameter int unsigned HBack   = H_BACK,
  parameter int unsigned VActive = V_ACTIVE,
  parameter int unsigned VFront  = V_FRONT,
  parameter int unsigned VSync   = V_SYNC,
  parameter int unsigned VBack   = V_BACK
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic [7:0]  idx_data,
  input  logic        idx_valid,
  output logic        idx_ready,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [14:0] pal_wdata,
  input  logic [3:0]  brightness,
  output logic [7:0]  pixel_r,
  output logic [7:0]  pixel_g,
  output logic [7:0]  pixel_b,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [8:0]  line_num,
  output logic        underflow,
  input  logic        underflow_clr
);

  localparam int unsigned HTotal = HActive + HFront + HSync + HBack;
  localparam int unsigned VTotal = VActive + VFront + VSync + VBack;

  localparam logic [CNT_W-1:0] HLast     = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast     = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HActEnd   = CNT_W'(HActive);
  localparam logic [CNT_W-1:0] VActEnd   = CNT_W'(VActive);
  localparam logic [CNT_W-1:0] HSyncBeg  = CNT_W'(HActive + HFront);
  localparam logic [CNT_W-1:0] HSyncEnd  = CNT_W'(HActive + HFront + HSync);
  localparam logic [CNT_W-1:0] VSyncBeg  = CNT_W'(VActive + VFront);
  localparam logic [CNT_W-1:0] VSyncEnd  = CNT_W'(VActive + VFront + VSync);

  // Stage 0: raster counters
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             active_s0, hsync_s0, vsync_s0;
  logic [7:0]       idx_s0;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_ce) begin
      if (h_cnt_q == HLast) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_s0 = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
  assign hsync_s0  = (h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd);
  assign vsync_s0  = (v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd);

  // Gated by reset_n so these combinational outputs read 0 while held in reset.
  assign idx_ready   = reset_n && pix_ce && active_s0;
  assign frame_start = reset_n && pix_ce && (h_cnt_q == '0) && (v_cnt_q == '0);

  // A missing index shows palette entry 0; the raster never stalls.
  assign idx_s0 = (idx_ready && idx_valid) ? idx_data : 8'h00;

  logic underflow_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= 1'b0;
    end else if (idx_ready && !idx_valid) begin
      underflow_q <= 1'b1;
    end else if (underflow_clr) begin
      underflow_q <= 1'b0;
    end
  end

  // Stage 1: index and timing, palette read address
  logic [7:0] idx1_q;
  logic       act1_q, hs1_q, vs1_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      idx1_q <= '0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
    end else if (pix_ce) begin
      idx1_q <= idx_s0;
      act1_q <= active_s0;
      hs1_q  <= hsync_s0;
      vs1_q  <= vsync_s0;
    end
  end

  // Stage 2: palette data plus timing delayed alongside it
  logic [14:0] pal_rdata;
  logic        act2_q, hs2_q, vs2_q;

  ppu_palette_ram u_palette (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .we_i    (pal_we),
    .waddr_i (pal_addr),
    .wdata_i (pal_wdata),
    .re_i    (pix_ce),
    .raddr_i (idx1_q),
    .rdata_o (pal_rdata)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      act2_q <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
    end else if (pix_ce) begin
      act2_q <= act1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  pixel_t pix_raw, pix_s2;

  assign pix_raw = rgb555_to_888(pal_rdata);

`ifdef PPU_FADE_EN
  // (c8 * (brightness + 1)) >> 4; max 255 * 16 fits in 12 bits.
  function automatic logic [7:0] fade(input logic [7:0] c8, input logic [3:0] br);
    logic [11:0] prod;
    prod = 12'(c8) * 12'({1'b0, br} + 5'd1);
    return prod[11:4];
  endfunction

  always_comb begin
    pix_s2   = pix_raw;
    pix_s2.r = fade(pix_raw.r, brightness);
    pix_s2.g = fade(pix_raw.g, brightness);
    pix_s2.b = fade(pix_raw.b, brightness);
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pix_s2 = pix_raw;
`endif

  // Stage 3: output registers
  pixel_t pix_q;
  logic   de_q, hs_q, vs_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else if (pix_ce) begin
      pix_q <= act2_q ? pix_s2 : '0;
      de_q  <= act2_q;
      hs_q  <= hs2_q;
      vs_q  <= vs2_q;
    end
  end

  assign pixel_r   = pix_q.r;
  assign pixel_g   = pix_q.g;
  assign pixel_b   = pix_q.b;
  assign de        = de_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;
  assign line_num  = v_cnt_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ppu_scanout.sv
// Self-checking bench for ppu_scanout using a reduced raster (25x11 total) so whole
// frames fit in a short run. A reference model follows the raster and palette at
// posedge and queues expected pixels; a monitor pops and compares on every enable.
// Build with PPU_FADE_EN defined to exercise brightness scaling.
module tb_ppu_scanout;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;

  logic        clk_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [7:0]  idx_data = '0;
  logic        idx_valid = 1'b0;
  logic        idx_ready;
  logic        pal_we = 1'b0;
  logic [7:0]  pal_addr = '0;
  logic [14:0] pal_wdata = '0;
  logic [3:0]  brightness = 4'd15;
  logic [7:0]  pixel_r, pixel_g, pixel_b;
  logic        hsync, vsync, de, frame_start, underflow;
  logic [8:0]  line_num;
  logic        underflow_clr = 1'b0;

  always #5 clk_in = ~clk_in;

  ppu_scanout #(
    .HActive(HA), .HFront(HF), .HSync(HS), .HBack(HB),
    .VActive(VA), .VFront(VF), .VSync(VS), .VBack(VB)
  ) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .pix_ce        (pix_ce),
    .idx_data      (idx_data),
    .idx_valid     (idx_valid),
    .idx_ready     (idx_ready),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_wdata     (pal_wdata),
    .brightness    (brightness),
    .pixel_r       (pixel_r),
    .pixel_g       (pixel_g),
    .pixel_b       (pixel_b),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .frame_start   (frame_start),
    .line_num      (line_num),
    .underflow     (underflow),
    .underflow_clr (underflow_clr)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic check_zero(input string name);
    check({name, "_video"}, 64'({pixel_r, pixel_g, pixel_b, hsync, vsync, de}), 64'd0);
    check({name, "_ctl"}, 64'({frame_start, idx_ready, underflow, line_num}), 64'd0);
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit de; bit hs; bit vs; logic [7:0] idx; } pend_t;
  typedef struct { bit de; bit hs; bit vs; logic [14:0] col; } exp_t;

  int          m_h, m_v;
  bit          m_uf;
  bit          m_act;
  logic [14:0] pal_m [256];
  pend_t       pend;
  bit          pend_v;
  exp_t        exp_q[$];

  function automatic bit in_active(int h, int v);
    return (h < HA) && (v < VA);
  endfunction

  function automatic logic [23:0] exp_rgb(input logic [14:0] col);
    logic [23:0] res;
    int c5, c8;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      c5 = (int'(col) >> (10 - 5 * ch)) & 31;
      c8 = c5 * 8 + c5 / 4;
      res = {res[15:0], 8'(c8)};
    end
    return res;
  endfunction

`ifdef PPU_FADE_EN
  function automatic logic [23:0] fade(input logic [23:0] rgb, input logic [3:0] br);
    logic [23:0] res;
    int c;
    for (int ch = 0; ch < 3; ch++) begin
      c = int'(rgb[23 - 8 * ch -: 8]);
      c = c * (int'(br) + 1) / 16;
      res[23 - 8 * ch -: 8] = 8'(c);
    end
    return res;
  endfunction
`endif

  // Each enabled pixel looks up the palette one enable after its position is taken,
  // seeing the table as it was before any write on that same edge.
  initial forever begin
    @(posedge clk_in);
    if (!reset_n) begin
      m_h = 0; m_v = 0; m_uf = 1'b0; pend_v = 1'b0;
      exp_q.delete();
    end else begin
      if (pix_ce) begin
        if (pend_v) exp_q.push_back('{de: pend.de, hs: pend.hs, vs: pend.vs,
                                      col: pal_m[pend.idx]});
        m_act   = in_active(m_h, m_v);
        pend.de = m_act;
        pend.hs = (m_h >= HA + HF) && (m_h < HA + HF + HS);
        pend.vs = (m_v >= VA + VF) && (m_v < VA + VF + VS);
        pend.idx = (m_act && idx_valid) ? idx_data : 8'h00;
        pend_v  = 1'b1;
        if (m_act && !idx_valid) m_uf = 1'b1;
        else if (underflow_clr) m_uf = 1'b0;
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end else if (underflow_clr) begin
        m_uf = 1'b0;
      end
    end
    if (pal_we) pal_m[pal_addr] = pal_wdata;
  end

  // ---------------- monitor: registered outputs ----------------
  bit          s_ce;
  logic [26:0] last_exp = '0;
  exp_t        e;
  logic [23:0] rgb;
`ifdef PPU_FADE_EN
  logic [3:0]  s_br;
`endif

  initial forever begin
    @(posedge clk_in);
    s_ce = pix_ce;
`ifdef PPU_FADE_EN
    s_br = brightness;
`endif
    #1;
    if (!reset_n) begin
      check_zero("reset");
      last_exp = '0;
    end else begin
      if (s_ce) begin
        if (exp_q.size() >= 2) begin
          e = exp_q.pop_front();
          rgb = e.de ? exp_rgb(e.col) : 24'h0;
`ifdef PPU_FADE_EN
          rgb = fade(rgb, s_br);
`endif
          last_exp = {e.de, e.hs, e.vs, rgb};
        end else begin
          last_exp = '0;
        end
      end
      check("video", 64'({de, hsync, vsync, pixel_r, pixel_g, pixel_b}), 64'(last_exp));
      check("underflow", 64'(underflow), 64'(m_uf));
      check("line_num", 64'(line_num), 64'(m_v));
    end
  end

  // ---------------- monitor: combinational outputs ----------------
  initial forever begin
    @(negedge clk_in);
    #2;
    if (!reset_n) begin
      check("ready_rst", 64'({idx_ready, frame_start}), 64'd0);
    end else begin
      check("idx_ready", 64'(idx_ready), 64'(pix_ce && in_active(m_h, m_v)));
      check("frame_start", 64'(frame_start), 64'(pix_ce && m_h == 0 && m_v == 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit ce, input bit valid, input logic [7:0] idx, input bit we,
                     input logic [7:0] a, input logic [14:0] d, input bit clr,
                     input logic [3:0] br);
    pix_ce = ce; idx_valid = valid; idx_data = idx;
    pal_we = we; pal_addr = a; pal_wdata = d;
    underflow_clr = clr; brightness = br;
    @(negedge clk_in);
  endtask

  task automatic wait_pos(input int h, input int v);
    for (int i = 0; i < HT * VT + 10; i++) begin
      if (m_h == h && m_v == v) break;
      cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    end
    check("align", 64'(m_h == h && m_v == v), 64'd1);
  endtask

  int fs_cnt, rdy_cnt, de_cnt, hs_cnt, vs_cnt;

  initial begin
    @(negedge clk_in);
    // Palette is loaded while held in reset; outputs must stay 0 regardless of inputs.
    for (int a = 0; a < 256; a++)
      cyc(1'b1, 1'($urandom), 8'($urandom), 1'b1, 8'(a), 15'($urandom),
          1'($urandom), 4'($urandom));
    #1;
    check_zero("reset_state");
    pal_we = 1'b0;

    // Three full frames with pix_ce high and indices always available.
    fs_cnt = 0; rdy_cnt = 0; de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int k = 0; k < 3 * HT * VT; k++) begin
      reset_n = 1'b1; pix_ce = 1'b1; idx_valid = 1'b1; idx_data = 8'($urandom);
      pal_we = 1'b0; underflow_clr = 1'b0; brightness = 4'($urandom);
      #2;
      fs_cnt += int'(frame_start); rdy_cnt += int'(idx_ready); de_cnt += int'(de);
      hs_cnt += int'(hsync); vs_cnt += int'(vsync);
      @(negedge clk_in);
    end
    check("frame_count", 64'(fs_cnt), 64'(3));
    check("ready_count", 64'(rdy_cnt), 64'(3 * HA * VA));
    check("de_count", 64'(de_cnt), 64'(3 * HA * VA));
    check("hsync_count", 64'(hs_cnt), 64'(3 * HS * VT));
    check("vsync_count", 64'(vs_cnt), 64'(3 * VS * HT));

    // Directed palette lookups at the frame origin.
    cyc(1'b0, 1'b1, 8'h0, 1'b1, 8'h12, 15'h7C00, 1'b0, 4'd15);
    cyc(1'b0, 1'b1, 8'h0, 1'b1, 8'h13, 15'h0421, 1'b0, 4'd15);
    wait_pos(0, 0);
    cyc(1'b1, 1'b1, 8'h12, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    cyc(1'b1, 1'b1, 8'h13, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    cyc(1'b1, 1'b1, 8'h44, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    check("pal_red", 64'({de, pixel_r, pixel_g, pixel_b}), {39'd0, 1'b1, 24'hFF0000});
    cyc(1'b1, 1'b1, 8'h45, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    check("pal_grey", 64'({de, pixel_r, pixel_g, pixel_b}), {39'd0, 1'b1, 24'h080808});

    // Underflow at (5,0), clear, then clear colliding with a new underflow.
    wait_pos(5, 0);
    cyc(1'b1, 1'b0, 8'h77, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    check("uf_set", 64'(underflow), 64'd1);
    cyc(1'b1, 1'b1, 8'h01, 1'b0, 8'h0, 15'h0, 1'b1, 4'd15);
    check("uf_clr", 64'(underflow), 64'd0);
    cyc(1'b1, 1'b0, 8'h02, 1'b0, 8'h0, 15'h0, 1'b1, 4'd15);
    check("uf_set_wins", 64'(underflow), 64'd1);
    check("uf_pixel", 64'({de, pixel_r, pixel_g, pixel_b}), 64'({1'b1, exp_rgb(pal_m[0])}));

    // Enable every 4th clock: outputs must only move on enabled edges.
    for (int i = 0; i < 200; i++)
      cyc(i % 4 == 0, 1'($urandom_range(0, 9) != 0), 8'($urandom), 1'b0, 8'h0, 15'h0,
          1'b0, 4'($urandom));

    // Read/write collision on entry 7.
    cyc(1'b0, 1'b1, 8'h0, 1'b1, 8'h07, 15'h001F, 1'b0, 4'd15);
    wait_pos(0, 3);
    cyc(1'b1, 1'b1, 8'h07, 1'b0, 8'h00, 15'h0000, 1'b0, 4'd15);
    cyc(1'b1, 1'b1, 8'h20, 1'b1, 8'h07, 15'h03E0, 1'b0, 4'd15);
    cyc(1'b1, 1'b1, 8'h07, 1'b0, 8'h00, 15'h0000, 1'b0, 4'd15);
    check("collide_old", 64'({de, pixel_r, pixel_g, pixel_b}), {39'd0, 1'b1, 24'h0000FF});
    cyc(1'b1, 1'b1, 8'h21, 1'b0, 8'h00, 15'h0000, 1'b0, 4'd15);
    cyc(1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 15'h0000, 1'b0, 4'd15);
    check("collide_new", 64'({de, pixel_r, pixel_g, pixel_b}), {39'd0, 1'b1, 24'h00FF00});

    // Randomised traffic: enables, missing indices, palette writes, clears, brightness.
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom), 1'($urandom_range(0, 9) != 0), 8'($urandom),
          1'($urandom_range(0, 9) == 0), 8'($urandom), 15'($urandom),
          1'($urandom_range(0, 19) == 0), 4'($urandom));

    // Asynchronous reset in the middle of an active line.
    wait_pos(10, 3);
    cyc(1'b1, 1'b1, 8'h07, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    cyc(1'b1, 1'b0, 8'h07, 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(negedge clk_in);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h0, 15'h0, 1'b0, 4'd15);
    reset_n = 1'b1; pix_ce = 1'b1; idx_valid = 1'b1;
    #2;
    check("fs_after_reset", 64'(frame_start), 64'd1);
    @(negedge clk_in);
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'b1, 8'($urandom), 1'b0, 8'h0, 15'h0, 1'b0, 4'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppu_scanout.md
Name: ppu_scanout

Overview:
- Final PPU stage. Generates the 320x200 raster timing and pulls one 8-bit colour index per active pixel from the layer compositor.
- Converts each index through a 256-entry RGB555 palette into RGB888.
- Drives pixel_r/g/b, hsync, vsync and de into the video scaler/LCD stage on clk_in.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- H_FRONT, 8, front porch pixels
- H_SYNC, 32, hsync pulse pixels
- H_BACK, 40, back porch pixels (H_TOTAL = 400)
- V_ACTIVE, 200, visible lines
- V_FRONT, 3, front porch lines
- V_SYNC, 4, vsync pulse lines
- V_BACK, 55, back porch lines (V_TOTAL = 262)

Ports:
- clk_in  in  1  system/PPU clock
- reset_n  in  1  reset, asynchronous, active-low
- pix_ce  in  1  pixel clock enable; all raster state advances only when high
- idx_data  in  8  palette index from compositor
- idx_valid  in  1  idx_data valid
- idx_ready  out  1  index consumed this cycle
- pal_we  in  1  palette write strobe
- pal_addr  in  8  palette write address
- pal_wdata  in  15  RGB555 {r[14:10], g[9:5], b[4:0]}
- brightness  in  4  master brightness (used only with PPU_FADE_EN)
- pixel_r / pixel_g / pixel_b  out  8 each  RGB888 output
- hsync  out  1  active-high line sync
- vsync  out  1  active-high frame sync
- de  out  1  active-video qualifier
- frame_start  out  1  one-cycle pulse at raster (0,0) on pix_ce
- line_num  out  9  current raster line, stage-0 aligned
- underflow  out  1  sticky: active pixel with no index available
- underflow_clr  in  1  clears underflow; a same-cycle set wins

Behaviour:
- Reset values: h_cnt = 0, v_cnt = 0. All outputs 0: pixel_r/g/b, hsync, vsync, de, frame_start, idx_ready, underflow, line_num.
- Palette contents are not reset.
- Stage 0 (counters), on pix_ce:
  - h_cnt wraps at H_TOTAL-1, then v_cnt increments.
  - v_cnt wraps at V_TOTAL-1.
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is high for H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC.
  - vsync is high for the equivalent window on v_cnt over full lines.
- Handshake:
  - idx_ready = pix_ce && active, combinational.
  - A transfer occurs when idx_ready && idx_valid.
  - When idx_ready && !idx_valid: substitute index 0, set underflow, and do not stall the raster.
  - Indices are never consumed outside active video.
- Stage 1: register index, active, hsync and vsync. Issue the palette read.
- Stage 2: the palette RAM produces data one cycle after the read. Expand each channel as {c[4:0], c[4:2]}.
- Stage 3: output registers. Latency is exactly 3 pix_ce cycles from counter position to de/pixel/sync.
- Sync/de pipeline: sync and de are delayed identically, so they stay aligned with the pixel data.
- Blanked pixels: when de = 0, pixel_r/g/b = 0.
- pix_ce low: pipeline registers hold. frame_start and idx_ready are 0.
- Palette write/read collision (same cycle, same address): read returns old data (read-first). The write is visible on the next read.
- Reset mid-line: all state returns to reset values immediately (asynchronous). The raster restarts at (0,0) on the first pix_ce after release.

Optional Feature:
- Macro: PPU_FADE_EN.
- Defined: in stage 3, each channel = (c8 * (brightness+1)) >> 4, using a 12-bit intermediate.
  - brightness = 15 gives identity; brightness = 0 gives c8 >> 4.
  - No added latency.
- Undefined: the brightness port exists but is ignored; output is the unscaled c8.

Decomposition:
- Package ppu_video_pkg holds:
  - the timing localparams (defaults above, H_TOTAL, V_TOTAL)
  - the rgb555 channel-expand function
  - a pixel struct/typedef {r, g, b}
- One sub-module, ppu_palette_ram: 256x15 simple dual-port, synchronous read-first, one write port and one read port, both on clk_in.

Test Plan:
- Frame timing, pix_ce tied high, idx_valid high:
  - de high 320 cycles per line for 200 lines; hsync high 32 cycles; vsync high 4x400 cycles.
  - frame_start every 104800 cycles.
  - idx_ready count per frame = 64000.
- Palette path:
  - Write pal_addr 0x12 = 15'h7C00, feed idx 0x12 at h=0,v=0 -> pixel = (FF,00,00) with de, 3 cycles later.
  - Write 15'h0421 -> (08,08,08).
- Underflow:
  - idx_valid low at pixel (5,0) -> that pixel shows palette[0] and underflow latches 1.
  - underflow_clr with no new underflow clears it.
  - Simultaneous clr and new underflow -> stays 1.
- pix_ce = 1 every 4th cycle -> outputs change only after pix_ce cycles; latency is 3 enables (12 clocks).
- Collision: write entry 7 while reading entry 7 in the same cycle -> old colour output, new colour on the next pixel using 7.
- PPU_FADE_EN with brightness = 7, colour FF -> 0x7F; brightness = 15 -> FF.
- Reset asserted at h=100,v=50 -> all outputs 0 asynchronously; after release, frame_start is the first pulse seen.
